// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID-stage operands in, tracker/stall/flush controls out.
// Latency: n/a (wiring only).
// Backpressure: n/a; stall/flush lines are the pipeline's backpressure.
interface hazard_ctrl_if #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
);
   logic [REG_W-1:0] iRs_D;
   logic [REG_W-1:0] iRt_D;
   logic             iUsesRt_D;
   logic [REG_W-1:0] iwsel_D;
   logic             iRegWrite_D;
   logic             iMemRead_D;
   logic             iBranchTaken;
   logic             iICacheStall;
   logic             iDCacheStall;
   logic [REG_W-1:0] owsel_E;
   logic             oRegWrite_E;
   logic             oMemRead_E;
   logic [REG_W-1:0] owsel_M;
   logic             oRegWrite_M;
   logic             oStall_PC;
   logic             oStall_IFID;
   logic             oStall_IDEX;
   logic             oStall_EXMEM;
   logic             oFlush_IFID;
   logic             oFlush_IDEX;
   logic [CNT_W-1:0] oStallCycles;

   // Pipeline side: drives ID-stage info and cache/branch events.
   modport master (
      output iRs_D, iRt_D, iUsesRt_D, iwsel_D, iRegWrite_D, iMemRead_D,
             iBranchTaken, iICacheStall, iDCacheStall,
      input  owsel_E, oRegWrite_E, oMemRead_E, owsel_M, oRegWrite_M,
             oStall_PC, oStall_IFID, oStall_IDEX, oStall_EXMEM,
             oFlush_IFID, oFlush_IDEX, oStallCycles
   );

   // Hazard controller side.
   modport slave (
      input  iRs_D, iRt_D, iUsesRt_D, iwsel_D, iRegWrite_D, iMemRead_D,
             iBranchTaken, iICacheStall, iDCacheStall,
      output owsel_E, oRegWrite_E, oMemRead_E, owsel_M, oRegWrite_M,
             oStall_PC, oStall_IFID, oStall_IDEX, oStall_EXMEM,
             oFlush_IFID, oFlush_IDEX, oStallCycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Tracks EX/MEM destinations, detects load-use, freezes on cache miss, applies (deferred) branch flushes.
// Latency: stall/flush combinational (0 cycles); tracker 1 cycle per stage.
// Backpressure: cache stall freezes all stages; load-use holds PC/IFID for one bubble cycle.
module hazard_ctrl #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.slave  hz
);

   typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

   state_t           state_q;
   logic             flush_pend_q;
   logic [REG_W-1:0] wsel_e_q, wsel_m_q;
   logic             rw_e_q, mr_e_q, rw_m_q;
   logic [CNT_W-1:0] cnt_q;

   logic [REG_W-1:0] wsel_e_d;
   logic             rw_e_d, mr_e_d;
   logic             freeze, flush_eff, lu;
   logic             stall_pc, stall_ifid, stall_idex, stall_exmem;
   logic             flush_ifid, flush_idex, stall_any;

   assign freeze    = hz.iICacheStall | hz.iDCacheStall;
   assign flush_eff = hz.iBranchTaken | flush_pend_q;
   assign lu        = mr_e_q & (wsel_e_q != '0) &
                      ((wsel_e_q == hz.iRs_D) | (hz.iUsesRt_D & (wsel_e_q == hz.iRt_D)));

   // Priority: reset, cache freeze, branch flush, load-use bubble.
   always_comb begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      stall_exmem = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      if (!rst_n) begin
         flush_idex = 1'b0;
      end else if (freeze) begin
         stall_pc    = 1'b1;
         stall_ifid  = 1'b1;
         stall_idex  = 1'b1;
         stall_exmem = 1'b1;
      end else if (flush_eff) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else if (lu) begin
         stall_pc   = 1'b1;
         stall_ifid = 1'b1;
         flush_idex = 1'b1;
      end
   end

   assign stall_any = stall_pc | stall_ifid | stall_idex | stall_exmem;

   // Next EX entry: ID instruction, or a bubble when ID/EX is flushed.
   always_comb begin
      wsel_e_d = hz.iwsel_D;
      rw_e_d   = hz.iRegWrite_D;
      mr_e_d   = hz.iMemRead_D;
      if (flush_idex) begin
         wsel_e_d = '0;
         rw_e_d   = 1'b0;
         mr_e_d   = 1'b0;
      end
   end

   // EX/MEM destination tracker; holds while the pipeline is frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wsel_e_q <= '0;
         rw_e_q   <= 1'b0;
         mr_e_q   <= 1'b0;
         wsel_m_q <= '0;
         rw_m_q   <= 1'b0;
      end else if (!freeze) begin
         wsel_m_q <= wsel_e_q;
         rw_m_q   <= rw_e_q;
         wsel_e_q <= wsel_e_d;
         rw_e_q   <= rw_e_d;
         mr_e_q   <= mr_e_d;
      end
   end

   // Freeze FSM; a branch seen while frozen is remembered and applied on the first free cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= RUN;
         flush_pend_q <= 1'b0;
      end else begin
         case (state_q)
            RUN:      if (freeze)  state_q <= MEM_WAIT;
            MEM_WAIT: if (!freeze) state_q <= RUN;
            default:  state_q <= RUN;
         endcase
         if (freeze && hz.iBranchTaken) flush_pend_q <= 1'b1;
         else if (!freeze)              flush_pend_q <= 1'b0;
      end
   end

   // Saturating count of cycles with any stall asserted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (stall_any && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign hz.owsel_E      = wsel_e_q;
   assign hz.oRegWrite_E  = rw_e_q;
   assign hz.oMemRead_E   = mr_e_q;
   assign hz.owsel_M      = wsel_m_q;
   assign hz.oRegWrite_M  = rw_m_q;
   assign hz.oStall_PC    = stall_pc;
   assign hz.oStall_IFID  = stall_ifid;
   assign hz.oStall_IDEX  = stall_idex;
   assign hz.oStall_EXMEM = stall_exmem;
   assign hz.oFlush_IFID  = flush_ifid;
   assign hz.oFlush_IDEX  = flush_idex;
   assign hz.oStallCycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded directed test of hazard_ctrl (CNT_W = 4 so saturation is reachable).
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares.
// Covers reset, load-use Rs/Rt, $0, non-load, deferred/overriding flush, saturation, async reset.
module tb_hazard_ctrl;

   typedef struct packed {
      logic [4:0] we;
      logic       rwe;
      logic       mre;
      logic [4:0] wm;
      logic       rwm;
      logic [3:0] st;   // PC, IFID, IDEX, EXMEM
      logic [1:0] fl;   // IFID, IDEX
      logic [3:0] cnt;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   hazard_ctrl_if #(.REG_W(5), .CNT_W(4)) hz ();

   hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz.slave)
   );

   always #5 clk = ~clk;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   function automatic exp_t mk(input logic [4:0] we, input logic rwe, input logic mre,
                               input logic [4:0] wm, input logic rwm,
                               input logic [3:0] st, input logic [1:0] fl, input logic [3:0] cnt);
      exp_t e;
      e.we = we; e.rwe = rwe; e.mre = mre; e.wm = wm; e.rwm = rwm;
      e.st = st; e.fl = fl; e.cnt = cnt;
      return e;
   endfunction

   // Drive one cycle of inputs just after the rising edge and queue what should appear.
   task automatic step(input string nm, input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ut, input logic [4:0] wsel, input logic rw, input logic mr,
                       input logic br, input logic ic, input logic dc, input exp_t e);
      @(posedge clk);
      #1;
      rst_n           = rst;
      hz.iRs_D        = rs;
      hz.iRt_D        = rt;
      hz.iUsesRt_D    = ut;
      hz.iwsel_D      = wsel;
      hz.iRegWrite_D  = rw;
      hz.iMemRead_D   = mr;
      hz.iBranchTaken = br;
      hz.iICacheStall = ic;
      hz.iDCacheStall = dc;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: compare every presented cycle against the oldest expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         exp_t  a;
         string nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = mk(hz.owsel_E, hz.oRegWrite_E, hz.oMemRead_E, hz.owsel_M, hz.oRegWrite_M,
                 {hz.oStall_PC, hz.oStall_IFID, hz.oStall_IDEX, hz.oStall_EXMEM},
                 {hz.oFlush_IFID, hz.oFlush_IDEX}, hz.oStallCycles);
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL %s: got wE=%0d rwE=%b mrE=%b wM=%0d rwM=%b st=%b fl=%b cnt=%0d ; want wE=%0d rwE=%b mrE=%b wM=%0d rwM=%b st=%b fl=%b cnt=%0d",
                     nm, a.we, a.rwe, a.mre, a.wm, a.rwm, a.st, a.fl, a.cnt,
                     e.we, e.rwe, e.mre, e.wm, e.rwm, e.st, e.fl, e.cnt);
         end
      end
   end

   initial begin
      hz.iRs_D = '0; hz.iRt_D = '0; hz.iUsesRt_D = 1'b0; hz.iwsel_D = '0;
      hz.iRegWrite_D = 1'b0; hz.iMemRead_D = 1'b0; hz.iBranchTaken = 1'b0;
      hz.iICacheStall = 1'b0; hz.iDCacheStall = 1'b0;
      #2 rst_n = 1'b0;

      //     name          rst rs  rt  ut wsel rw mr br ic dc   expected: wE rwE mrE wM rwM st  fl cnt
      step("reset",        0,  0,  0,  0, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 0));
      // load-use on Rs
      step("lu_rs_load",   1,  0,  0,  0, 8,   1, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 0));
      step("lu_rs_stall",  1,  8,  0,  0, 3,   1, 0, 0, 0, 0, mk(8, 1, 1, 0, 0, 4'b1100, 2'b01, 0));
      step("lu_rs_bubble", 1,  8,  0,  0, 3,   1, 0, 0, 0, 0, mk(0, 0, 0, 8, 1, 4'b0000, 2'b00, 1));
      // non-load producer
      step("add_issue",    1,  0,  0,  0, 9,   1, 0, 0, 0, 0, mk(3, 1, 0, 0, 0, 4'b0000, 2'b00, 1));
      step("add_in_E",     1,  9,  0,  0, 0,   0, 0, 0, 0, 0, mk(9, 1, 0, 3, 1, 4'b0000, 2'b00, 1));
      step("add_in_M",     1,  0,  0,  0, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 9, 1, 4'b0000, 2'b00, 1));
      // Rt gating
      step("rt_load_a",    1,  0,  0,  0, 10,  1, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 1));
      step("rt_unused",    1,  0,  10, 0, 0,   0, 0, 0, 0, 0, mk(10,1, 1, 0, 0, 4'b0000, 2'b00, 1));
      step("rt_load_b",    1,  0,  0,  0, 10,  1, 1, 0, 0, 0, mk(0, 0, 0, 10,1, 4'b0000, 2'b00, 1));
      step("rt_used",      1,  0,  10, 1, 0,   0, 0, 0, 0, 0, mk(10,1, 1, 0, 0, 4'b1100, 2'b01, 1));
      step("rt_bubble",    1,  0,  10, 1, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 10,1, 4'b0000, 2'b00, 2));
      // $0 load never stalls
      step("r0_load",      1,  0,  0,  0, 0,   1, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 2));
      step("r0_use",       1,  0,  0,  1, 0,   0, 0, 0, 0, 0, mk(0, 1, 1, 0, 0, 4'b0000, 2'b00, 2));
      step("r0_in_M",      1,  0,  0,  0, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 4'b0000, 2'b00, 2));
      // deferred flush across a D-cache stall
      step("df_reset",     0,  0,  0,  0, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 0));
      step("df_fill",      1,  0,  0,  0, 5,   1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 0));
      step("df_stall1",    1,  0,  0,  0, 6,   1, 0, 0, 0, 1, mk(5, 1, 0, 0, 0, 4'b1111, 2'b00, 0));
      step("df_stall2_br", 1,  0,  0,  0, 6,   1, 0, 1, 0, 1, mk(5, 1, 0, 0, 0, 4'b1111, 2'b00, 1));
      step("df_stall3",    1,  0,  0,  0, 6,   1, 0, 0, 0, 1, mk(5, 1, 0, 0, 0, 4'b1111, 2'b00, 2));
      step("df_flush",     1,  0,  0,  0, 6,   1, 0, 0, 0, 0, mk(5, 1, 0, 0, 0, 4'b0000, 2'b11, 3));
      step("df_after",     1,  0,  0,  0, 6,   1, 0, 0, 0, 0, mk(0, 0, 0, 5, 1, 4'b0000, 2'b00, 3));
      // branch overrides load-use
      step("ov_load",      1,  0,  0,  0, 7,   1, 1, 0, 0, 0, mk(6, 1, 0, 0, 0, 4'b0000, 2'b00, 3));
      step("ov_branch",    1,  7,  0,  0, 0,   0, 0, 1, 0, 0, mk(7, 1, 1, 6, 1, 4'b0000, 2'b11, 3));
      step("ov_after",     1,  0,  0,  0, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 7, 1, 4'b0000, 2'b00, 3));
      // saturation with a 4-bit counter
      for (int i = 0; i < 20; i++) begin
         logic [3:0] c;
         c = (3 + i > 15) ? 4'd15 : 4'(3 + i);
         step("sat_icache", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 4'b1111, 2'b00, c));
      end
      step("rst_mid_stall",0,  0,  0,  0, 0,   0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 0));
      step("rst_release",  1,  0,  0,  0, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 0));
      // pending flush discarded by reset
      step("pd_stall_br",  1,  0,  0,  0, 0,   0, 0, 1, 0, 1, mk(0, 0, 0, 0, 0, 4'b1111, 2'b00, 0));
      step("pd_reset",     0,  0,  0,  0, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 0));
      step("pd_no_flush",  1,  0,  0,  0, 0,   0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 4'b0000, 2'b00, 0));

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
